// File: rtl/relay_encode_param.sv
// Relay-line pulse encoder.
// Oversamples a serial relay stream, compares the most recent PATTERN_W samples
// against two masked runtime patterns and emits a PULSE_LEN-cycle pulse per match.
// Optional statistics counters are built when RELAY_ENC_STATS_EN is defined;
// otherwise hit_cnt and drop_cnt are tied to zero.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_FILL  | fewer than PATTERN_W samples collected since reset/match
//   ST_ARMED | sample window full, comparing on every strobe
//   ST_PULSE | output pulse running (pulse_cnt != 0)
module relay_encode_param #(
   parameter int SAMPLE_DIV = 16,
   parameter int PATTERN_W  = 4,
   parameter int PULSE_LEN  = 64,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 data_in,
   input  logic [PATTERN_W-1:0] pat_a,
   input  logic [PATTERN_W-1:0] mask_a,
   input  logic [PATTERN_W-1:0] pat_b,
   input  logic [PATTERN_W-1:0] mask_b,
   input  logic                 retrig,
   output logic                 data_out,
   output logic                 busy,
   output logic [CNT_W-1:0]     hit_cnt,
   output logic [CNT_W-1:0]     drop_cnt
);

   localparam int DIV_W  = $clog2(SAMPLE_DIV);
   localparam int FILL_W = $clog2(PATTERN_W + 1);
   localparam int PCNT_W = $clog2(PULSE_LEN + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);
   localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(PULSE_LEN);

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_ARMED = 2'd1,
      ST_PULSE = 2'd2
   } state_t;

   state_t              state, state_d;
   logic [DIV_W-1:0]    div_cnt, div_d;
   // The oldest sample drops out of the window on every strobe, so only the
   // newest PATTERN_W-1 samples need to be held between strobes.
   logic [PATTERN_W-2:0] shift_q, shift_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic [PCNT_W-1:0]   pulse_cnt, pulse_d;

   logic                 strobe;
   logic [PATTERN_W-1:0] window;
   logic [FILL_W-1:0]    fill_inc;
   logic                 hit_a, hit_b;
   logic                 match;
   logic                 match_acc;

   assign strobe    = en && (div_cnt == DIV_LAST);
   assign window    = {shift_q, data_in};
   assign fill_inc  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
   assign hit_a     = (|mask_a) && (((window ^ pat_a) & mask_a) == '0);
   assign hit_b     = (|mask_b) && (((window ^ pat_b) & mask_b) == '0);
   assign match     = strobe && (fill_inc == FILL_FULL) && (hit_a || hit_b);
   // A match while a pulse runs is only accepted in retrigger mode.
   assign match_acc = match && ((state != ST_PULSE) || retrig);

   assign data_out  = (pulse_cnt != '0);
   assign busy      = data_out;

   // Registered state: prescaler, sample window, fill level, pulse timer, FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_FILL;
         div_cnt   <= '0;
         shift_q   <= '0;
         fill_q    <= '0;
         pulse_cnt <= '0;
      end else begin
         state     <= state_d;
         div_cnt   <= div_d;
         shift_q   <= shift_d;
         fill_q    <= fill_d;
         pulse_cnt <= pulse_d;
      end
   end

   // Next-state logic for the prescaler, window, pulse timer and FSM.
   always_comb begin
      state_d = state;
      div_d   = div_cnt;
      shift_d = shift_q;
      fill_d  = fill_q;
      pulse_d = pulse_cnt;

      if (en) begin
         div_d = strobe ? '0 : div_cnt + 1'b1;
      end

      // The pulse timer runs independently of en so a pulse always completes.
      if (pulse_cnt != '0) begin
         pulse_d = pulse_cnt - 1'b1;
      end

      // Any match, accepted or dropped, demands a complete fresh pattern.
      if (strobe) begin
         if (match) begin
            shift_d = '0;
            fill_d  = '0;
         end else begin
            shift_d = window[PATTERN_W-2:0];
            fill_d  = fill_inc;
         end
      end

      if (match_acc) begin
         pulse_d = PCNT_LOAD;
         state_d = ST_PULSE;
      end else begin
         case (state)
            ST_FILL: begin
               if (fill_d == FILL_FULL) state_d = ST_ARMED;
            end
            ST_ARMED: begin
               state_d = ST_ARMED;
            end
            ST_PULSE: begin
               // The window kept filling during the pulse; resume where it stands.
               if (pulse_d == '0) state_d = (fill_d == FILL_FULL) ? ST_ARMED : ST_FILL;
            end
            default: begin
               state_d = ST_FILL;
            end
         endcase
      end
   end

`ifdef RELAY_ENC_STATS_EN
   logic             match_drop;
   logic [CNT_W-1:0] hit_q, drop_q;

   assign match_drop = match && (state == ST_PULSE) && !retrig;

   // Saturating accepted/dropped match counters, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_q  <= '0;
         drop_q <= '0;
      end else begin
         if (match_acc && (hit_q != '1))   hit_q  <= hit_q + 1'b1;
         if (match_drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      end
   end

   assign hit_cnt  = hit_q;
   assign drop_cnt = drop_q;
`else
   assign hit_cnt  = '0;
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_relay_encode_param.sv
// Directed bench for relay_encode_param: one default instance (PULSE_LEN=64)
// and one long-pulse instance (PULSE_LEN=128, CNT_W=2) sharing the same stimulus.
module tb_relay_encode_param;

`ifdef RELAY_ENC_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b1;
   logic        data_in = 1'b0;
   logic [3:0]  pat_a = 4'hC, mask_a = 4'hF, pat_b = 4'hF, mask_b = 4'hF;
   logic        retrig = 1'b0;

   logic        data0, busy0, data1, busy1;
   logic [15:0] hit0, drop0;
   logic [1:0]  hit1, drop1;

   int checks = 0;
   int errors = 0;
   int hi0, hi1;

   always #5 clk = ~clk;

   relay_encode_param u_dut0 (
      .clk(clk), .reset(reset), .en(en), .data_in(data_in),
      .pat_a(pat_a), .mask_a(mask_a), .pat_b(pat_b), .mask_b(mask_b),
      .retrig(retrig), .data_out(data0), .busy(busy0),
      .hit_cnt(hit0), .drop_cnt(drop0)
   );

   relay_encode_param #(.PULSE_LEN(128), .CNT_W(2)) u_dut1 (
      .clk(clk), .reset(reset), .en(en), .data_in(data_in),
      .pat_a(pat_a), .mask_a(mask_a), .pat_b(pat_b), .mask_b(mask_b),
      .retrig(retrig), .data_out(data1), .busy(busy1),
      .hit_cnt(hit1), .drop_cnt(drop1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n clocks, sampling 1 time unit after each edge and counting high cycles.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         hi0 += int'(data0);
         hi1 += int'(data1);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run(2);
      reset = 1'b0;
      hi0 = 0;
      hi1 = 0;
   endtask

   task automatic send(input logic b);
      data_in = b;
      run(16);
   endtask

   function automatic logic [31:0] st(input int v);
      return STATS ? 32'(v) : 32'd0;
   endfunction

   initial begin
      hi0 = 0;
      hi1 = 0;

      // Reset state
      do_reset();
      chk("rst_data0", data0, 0);
      chk("rst_busy0", busy0, 0);
      chk("rst_hit0", hit0, 0);
      chk("rst_drop0", drop0, 0);
      chk("rst_data1", data1, 0);
      chk("rst_hit1", hit1, 0);
      chk("rst_drop1", drop1, 0);

      // Constant ones, no retrigger
      data_in = 1'b1;
      retrig  = 1'b0;
      run(63);
      chk("ones_pre_rise", data0, 0);
      run(1);
      chk("ones_rise0", data0, 1);
      chk("ones_busy0", busy0, 1);
      chk("ones_rise1", data1, 1);
      run(63);
      chk("ones_last_high0", data0, 1);
      run(1);
      chk("ones_fall0", data0, 0);
      chk("ones_still1", data1, 1);
      run(63);
      chk("ones_gap0", data0, 0);
      run(1);
      chk("ones_next_pulse0", data0, 1);
      chk("ones_fall1", data1, 0);
      chk("ones_hit0", hit0, st(2));
      chk("ones_drop0", drop0, st(1));
      chk("ones_hit1", hit1, st(1));
      chk("ones_drop1", drop1, st(2));

      // Retrigger: output never falls; 5 accepted matches saturate the 2-bit counter
      do_reset();
      retrig = 1'b1;
      run(64);
      chk("retrig_rise1", data1, 1);
      hi0 = 0;
      hi1 = 0;
      run(266);
      chk("retrig_high0", hi0, 266);
      chk("retrig_high1", hi1, 266);
      chk("retrig_hit0", hit0, st(5));
      chk("retrig_hit1_sat", hit1, st(3));
      chk("retrig_drop1", drop1, 0);
      retrig = 1'b0;

      // Samples 1,1,0,0 then zeros: exactly one 64-cycle pulse
      do_reset();
      send(1'b1); send(1'b1); send(1'b0);
      chk("p1100_pre", data0, 0);
      send(1'b0);
      chk("p1100_rise", data0, 1);
      for (int i = 0; i < 4; i++) send(1'b0);
      chk("p1100_one_pulse", hi0, 64);

      // Alternating samples never match
      do_reset();
      for (int i = 0; i < 8; i++) send(i[0] ? 1'b0 : 1'b1);
      chk("p1010_none", hi0, 0);

      // Partial mask: only the two oldest bits compared
      do_reset();
      mask_a = 4'hC;
      mask_b = 4'h0;
      send(1'b1); send(1'b1); send(1'b1);
      chk("mask_pre", data0, 0);
      send(1'b0);
      chk("mask_partial_hit", data0, 1);

      // Both patterns disabled
      do_reset();
      mask_a = 4'h0;
      data_in = 1'b1;
      run(200);
      send(1'b1); send(1'b1); send(1'b0); send(1'b0);
      chk("masks_off0", hi0, 0);
      chk("masks_off1", hi1, 0);
      mask_a = 4'hF;
      mask_b = 4'hF;

      // Enable low freezes sampling but not a running pulse
      do_reset();
      data_in = 1'b1;
      run(32);
      en = 1'b0;
      run(200);
      chk("en_off_no_pulse", hi0, 0);
      en = 1'b1;
      run(31);
      chk("en_resume_pre", data0, 0);
      run(1);
      chk("en_resume_rise", data0, 1);
      en = 1'b0;
      run(63);
      chk("en_off_pulse_runs", data0, 1);
      run(1);
      chk("en_off_pulse_ends", data0, 0);
      en = 1'b1;

      // Reset 10 clocks into a pulse
      do_reset();
      data_in = 1'b1;
      run(74);
      chk("midrst_pre", data0, 1);
      reset = 1'b1;
      run(1);
      chk("midrst_clear0", data0, 0);
      chk("midrst_clear1", data1, 0);
      reset = 1'b0;
      run(63);
      chk("midrst_refill", data0, 0);
      run(1);
      chk("midrst_rematch", data0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
